// File: rtl/zibal_reset_pkg.sv
// Shared types for the Carbon1 reset sequencer: FSM states, reset-cause codes
// and a helper for sizing the shared cycle counter.
package zibal_reset_pkg;

  typedef enum logic [1:0] {
    POR   = 2'd0,
    FLASH = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } state_e;

  typedef logic [1:0] cause_t;

  localparam cause_t CAUSE_POR    = 2'b00;
  localparam cause_t CAUSE_BUTTON = 2'b01;
  localparam cause_t CAUSE_SOFT   = 2'b10;

  function automatic int unsigned maxOf3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/zibal_reset_sequencer_if.sv
// Board-side signals of the reset sequencer: button and SoC request in,
// divided clock, resets and latched cause out.
interface zibal_reset_sequencer_if;
  import zibal_reset_pkg::*;

  logic   io_button_n;
  logic   io_sysReset_req;
  logic   io_sysClock;
  logic   io_sysReset;
  logic   io_flashReset;
  cause_t io_resetCause;

  modport master (
    input  io_button_n, io_sysReset_req,
    output io_sysClock, io_sysReset, io_flashReset, io_resetCause
  );

  modport slave (
    output io_button_n, io_sysReset_req,
    input  io_sysClock, io_sysReset, io_flashReset, io_resetCause
  );

endinterface

// File: rtl/zibal_sync_debounce.sv
// Two-flop synchronizer with an optional debounce filter; DEBOUNCE_CYCLES=0
// passes the synchronized level straight through.
module zibal_sync_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  parameter logic        RESET_VALUE     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic level_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {2{RESET_VALUE}};
    end else begin
      sync_q <= {sync_q[0], async_i};
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : gBypass
      assign level_o = sync_q[1];
    end else begin : gDebounce
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

      logic [CW-1:0] cnt_q;
      logic          stable_q;

      // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          cnt_q    <= '0;
          stable_q <= RESET_VALUE;
        end else if (sync_q[1] == stable_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt_q    <= '0;
          stable_q <= sync_q[1];
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end

      assign level_o = stable_q;
    end
  endgenerate

endmodule

// File: rtl/zibal_reset_sequencer.sv
// Carbon1 upstream reset stage: divides the board clock, sequences flash then
// SoC reset release, and records why the last reset happened.
module zibal_reset_sequencer
  import zibal_reset_pkg::*;
#(
  parameter int unsigned CLK_DIV         = 2,
  parameter int unsigned POR_CYCLES      = 64,
  parameter int unsigned STRETCH_CYCLES  = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input logic                     io_clock,
  input logic                     io_reset,
  zibal_reset_sequencer_if.master bus
);

  localparam int unsigned CNT_MAX = maxOf3(POR_CYCLES, STRETCH_CYCLES, DEBOUNCE_CYCLES);
  localparam int CW   = $clog2(CNT_MAX + 1);
  localparam int HALF = CLK_DIV / 2;
  localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic [1:0]    rstSync_q;
  logic          rstSync;
  logic [DW-1:0] divCnt_q;
  logic          sysClock_q;
  logic          btnStable;
  logic          reqSync;
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          sysReset_q;
  logic          flashReset_q;
  cause_t        cause_q;

  always_ff @(posedge io_clock or negedge io_reset) begin
    if (!io_reset) begin
      rstSync_q <= '0;
    end else begin
      rstSync_q <= {rstSync_q[0], 1'b1};
    end
  end

  assign rstSync = rstSync_q[1];

  always_ff @(posedge io_clock or negedge io_reset) begin
    if (!io_reset) begin
      divCnt_q   <= '0;
      sysClock_q <= 1'b0;
    end else if (rstSync) begin
      if (divCnt_q == DW'(HALF - 1)) begin
        divCnt_q   <= '0;
        sysClock_q <= ~sysClock_q;
      end else begin
        divCnt_q <= divCnt_q + DW'(1);
      end
    end
  end

  zibal_sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_VALUE    (1'b1)
  ) uButton (
    .clk_i  (io_clock),
    .rst_ni (io_reset),
    .async_i(bus.io_button_n),
    .level_o(btnStable)
  );

  zibal_sync_debounce #(
    .DEBOUNCE_CYCLES(0),
    .RESET_VALUE    (1'b0)
  ) uRequest (
    .clk_i  (io_clock),
    .rst_ni (io_reset),
    .async_i(bus.io_sysReset_req),
    .level_o(reqSync)
  );

  // The counter is reloaded to 1 on entering a timed state so it already
  // includes the entry cycle and every state lasts exactly its cycle count.
  always_ff @(posedge io_clock or negedge io_reset) begin
    if (!io_reset) begin
      state_q      <= POR;
      cnt_q        <= '0;
      sysReset_q   <= 1'b0;
      flashReset_q <= 1'b0;
      cause_q      <= CAUSE_POR;
    end else if (rstSync) begin
      unique case (state_q)
        POR: begin
          if (cnt_q == CW'(POR_CYCLES)) begin
            state_q      <= FLASH;
            cnt_q        <= CW'(1);
            flashReset_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        FLASH: begin
          if (cnt_q == CW'(STRETCH_CYCLES)) begin
            state_q    <= RUN;
            sysReset_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RUN: begin
          if (!btnStable || reqSync) begin
            state_q      <= HOLD;
            cnt_q        <= CW'(1);
            sysReset_q   <= 1'b0;
            flashReset_q <= 1'b0;
            cause_q      <= !btnStable ? CAUSE_BUTTON : CAUSE_SOFT;
          end
        end
        HOLD: begin
          if (cnt_q == CW'(STRETCH_CYCLES)) begin
            if (btnStable) begin
              state_q <= POR;
              cnt_q   <= CW'(1);
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= POR;
      endcase
    end
  end

  assign bus.io_sysClock   = sysClock_q;
  assign bus.io_sysReset   = sysReset_q;
  assign bus.io_flashReset = flashReset_q;
  assign bus.io_resetCause = cause_q;

endmodule

// File: tb/tb_zibal_reset_sequencer.sv
// Directed bench for zibal_reset_sequencer: power-on sequencing, button debounce,
// software request, source priority and asynchronous reset in HOLD.
module tb_zibal_reset_sequencer;
  import zibal_reset_pkg::*;

  localparam int D = 1000;
  localparam int P = 64;
  localparam int S = 16;

  logic io_clock = 1'b0;
  logic io_reset = 1'b1;
  int   cyc      = -1;
  int   total    = 0;
  int   bad      = 0;

  zibal_reset_sequencer_if bus ();

  zibal_reset_sequencer #(
    .CLK_DIV        (2),
    .POR_CYCLES     (P),
    .STRETCH_CYCLES (S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .io_clock(io_clock),
    .io_reset(io_reset),
    .bus     (bus)
  );

  always #5 io_clock = ~io_clock;

  // cyc equals k just after the k-th rising edge with io_reset high (first is 0).
  always @(posedge io_clock or negedge io_reset) begin
    if (!io_reset) cyc <= -1;
    else           cyc <= cyc + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic buttonN, input logic req);
    bus.io_button_n     = buttonN;
    bus.io_sysReset_req = req;
  endtask

  task automatic gotoCycle(input int k);
    int guard = 0;
    while (cyc < k && guard < 20000) begin
      @(posedge io_clock);
      #1;
      guard++;
    end
    if (cyc < k) checkOutput("gotoCycle timeout", cyc, k);
  endtask

  initial begin
    int c, x, h;
    applyStimulus(1'b1, 1'b0);
    #1 io_reset = 1'b0;
    repeat (5) @(posedge io_clock);
    #1;
    checkOutput("reset sysClock", bus.io_sysClock, 0);
    checkOutput("reset sysReset", bus.io_sysReset, 0);
    checkOutput("reset flashReset", bus.io_flashReset, 0);
    checkOutput("reset cause", bus.io_resetCause, 0);
    @(negedge io_clock);
    io_reset = 1'b1;

    gotoCycle(1);  checkOutput("sysClock c1", bus.io_sysClock, 0);
    gotoCycle(2);  checkOutput("sysClock c2", bus.io_sysClock, 1);
    gotoCycle(3);  checkOutput("sysClock c3", bus.io_sysClock, 0);
    gotoCycle(65); checkOutput("por flash c65", bus.io_flashReset, 0);
    gotoCycle(66); checkOutput("por flash c66", bus.io_flashReset, 1);
    checkOutput("por sys c66", bus.io_sysReset, 0);
    gotoCycle(81); checkOutput("por sys c81", bus.io_sysReset, 0);
    gotoCycle(82); checkOutput("por sys c82", bus.io_sysReset, 1);
    checkOutput("por cause", bus.io_resetCause, CAUSE_POR);

    c = 100;
    gotoCycle(c);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0);
      gotoCycle(c + 999);
      applyStimulus(1'b1, 1'b0);
      c += 1000;
      gotoCycle(c);
      checkOutput("bounce sys", bus.io_sysReset, 1);
    end
    gotoCycle(c + D + 10);
    checkOutput("bounce sys after", bus.io_sysReset, 1);
    checkOutput("bounce flash after", bus.io_flashReset, 1);

    c = cyc;
    applyStimulus(1'b0, 1'b0);
    gotoCycle(c + D + 2); checkOutput("btn sys before drop", bus.io_sysReset, 1);
    gotoCycle(c + D + 3); checkOutput("btn sys drop", bus.io_sysReset, 0);
    checkOutput("btn flash drop", bus.io_flashReset, 0);
    checkOutput("btn cause", bus.io_resetCause, CAUSE_BUTTON);
    gotoCycle(c + 5000); checkOutput("btn held sys", bus.io_sysReset, 0);
    applyStimulus(1'b1, 1'b0);
    x = c + 5003 + D;
    gotoCycle(x - 1);  checkOutput("btn hold end flash", bus.io_flashReset, 0);
    gotoCycle(x + 63); checkOutput("btn flash c63", bus.io_flashReset, 0);
    gotoCycle(x + 64); checkOutput("btn flash c64", bus.io_flashReset, 1);
    checkOutput("btn sys c64", bus.io_sysReset, 0);
    gotoCycle(x + 79); checkOutput("btn sys c79", bus.io_sysReset, 0);
    gotoCycle(x + 80); checkOutput("btn sys c80", bus.io_sysReset, 1);
    checkOutput("btn cause after", bus.io_resetCause, CAUSE_BUTTON);

    c = cyc + 10;
    gotoCycle(c);
    applyStimulus(1'b1, 1'b1);
    gotoCycle(c + 1); applyStimulus(1'b1, 1'b0);
    gotoCycle(c + 2); checkOutput("soft sys before drop", bus.io_sysReset, 1);
    gotoCycle(c + 3); checkOutput("soft sys drop", bus.io_sysReset, 0);
    checkOutput("soft cause", bus.io_resetCause, CAUSE_SOFT);
    h = c + 3;
    gotoCycle(h + 79); checkOutput("soft flash h79", bus.io_flashReset, 0);
    gotoCycle(h + 80); checkOutput("soft flash h80", bus.io_flashReset, 1);
    gotoCycle(h + 95); checkOutput("soft sys h95", bus.io_sysReset, 0);
    gotoCycle(h + 96); checkOutput("soft sys h96", bus.io_sysReset, 1);
    checkOutput("soft cause after", bus.io_resetCause, CAUSE_SOFT);

    c = cyc + 10;
    gotoCycle(c);
    applyStimulus(1'b0, 1'b0);
    gotoCycle(c + D);     applyStimulus(1'b0, 1'b1);
    gotoCycle(c + D + 1); applyStimulus(1'b0, 1'b0);
    gotoCycle(c + D + 2); checkOutput("both sys before drop", bus.io_sysReset, 1);
    gotoCycle(c + D + 3); checkOutput("both sys drop", bus.io_sysReset, 0);
    checkOutput("both cause", bus.io_resetCause, CAUSE_BUTTON);
    gotoCycle(c + D + 10); applyStimulus(1'b1, 1'b0);
    x = c + 2 * D + 13;
    gotoCycle(x + 70); applyStimulus(1'b1, 1'b1);
    gotoCycle(x + 71); applyStimulus(1'b1, 1'b0);
    gotoCycle(x + 80);  checkOutput("flash-req sys rise", bus.io_sysReset, 1);
    gotoCycle(x + 120); checkOutput("flash-req sys later", bus.io_sysReset, 1);
    checkOutput("flash-req flash later", bus.io_flashReset, 1);
    checkOutput("flash-req cause", bus.io_resetCause, CAUSE_BUTTON);

    c = cyc + 10;
    gotoCycle(c);
    applyStimulus(1'b1, 1'b1);
    gotoCycle(c + 1); applyStimulus(1'b1, 1'b0);
    gotoCycle(c + 8);
    checkOutput("hold cause before async", bus.io_resetCause, CAUSE_SOFT);
    #3 io_reset = 1'b0;
    #1;
    checkOutput("async sysClock", bus.io_sysClock, 0);
    checkOutput("async sysReset", bus.io_sysReset, 0);
    checkOutput("async flashReset", bus.io_flashReset, 0);
    checkOutput("async cause", bus.io_resetCause, CAUSE_POR);
    repeat (3) @(posedge io_clock);
    @(negedge io_clock);
    io_reset = 1'b1;
    gotoCycle(65); checkOutput("re-por flash c65", bus.io_flashReset, 0);
    gotoCycle(82); checkOutput("re-por sys c82", bus.io_sysReset, 1);
    checkOutput("re-por cause", bus.io_resetCause, CAUSE_POR);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
